// File: rtl/sm83_idu_pkg.sv
// rtl/sm83_idu_pkg.sv - shared types and constants for the SM83 increment/decrement stage
//
// Purpose : op encoding, FSM state encoding and the OAM window bounds used by
//           sm83_idu_stage and sm83_idu_adder.
// Ports   : none (package).
package sm83_idu_pkg;

    // Operation requested of the IDU; encoding 2'd3 is reserved and behaves as PASS.
    typedef enum logic [1:0] {
        PASS = 2'd0,
        INC  = 2'd1,
        DEC  = 2'd2
    } idu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } idu_state_t;

    // Sprite attribute memory window; INC/DEC on a pointer in here trips the OAM bug.
    localparam logic [15:0] OAM_LO = 16'hFE00;
    localparam logic [15:0] OAM_HI = 16'hFEFF;

endpackage

// File: rtl/sm83_idu_adder.sv
// rtl/sm83_idu_adder.sv - combinational 16-bit +1/-1 built as two chained 8-bit halves
//
// Purpose : computes addr+1 (INC), addr-1 (DEC) or addr (PASS / reserved op).
// Ports   : addr    in  16  register-pair value
//           op      in   2  operation (PASS/INC/DEC, 3 = reserved)
//           sum     out 16  result modulo 2^16
//           carry_l out  1  low-byte carry (INC) / borrow (DEC) into the high byte
//           wrap    out  1  carry/borrow out of the high byte
module sm83_idu_adder
    import sm83_idu_pkg::*;
(
    input  logic [15:0] addr,
    input  logic [1:0]  op,
    output logic [15:0] sum,
    output logic        carry_l,
    output logic        wrap
);

    // Bit 8 of each 9-bit half is the carry/borrow out of that byte.
    logic [8:0] lo_ext;
    logic [8:0] hi_ext;

    always_comb begin
        lo_ext  = {1'b0, addr[7:0]};
        hi_ext  = {1'b0, addr[15:8]};
        sum     = addr;
        carry_l = 1'b0;
        wrap    = 1'b0;
        case (op)
            INC: begin
                lo_ext  = {1'b0, addr[7:0]} + 9'd1;
                carry_l = lo_ext[8];
                hi_ext  = {1'b0, addr[15:8]} + {8'd0, carry_l};
                wrap    = hi_ext[8];
                sum     = {hi_ext[7:0], lo_ext[7:0]};
            end
            DEC: begin
                lo_ext  = {1'b0, addr[7:0]} - 9'd1;
                carry_l = lo_ext[8];
                hi_ext  = {1'b0, addr[15:8]} - {8'd0, carry_l};
                wrap    = hi_ext[8];
                sum     = {hi_ext[7:0], lo_ext[7:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sm83_idu_stage.sv
// rtl/sm83_idu_stage.sv - handshaked SM83 increment/decrement unit stage (IDLE/CALC/DONE)
//
// Purpose : accepts a register-pair value with an op and a destination tag, computes
//           +1/-1/pass in the CALC cycle and presents the result until consumed.
// Ports   : clk, reset (sync, active-high)
//           req_valid/req_ready, req_op[1:0], req_addr[15:0], req_tag[2:0]  request side
//           res_valid/res_ready, res_addr[15:0], res_tag[2:0],
//           res_carry_l, res_wrap, oam_bug                              result side
// Config  : SM83_IDU_OAM_BUG_EN - when defined, oam_bug flags INC/DEC on a pointer in
//           FE00..FEFF; when undefined, oam_bug is tied to 0.
module sm83_idu_stage
    import sm83_idu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [2:0]  req_tag,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_addr,
    output logic [2:0]  res_tag,
    output logic        res_carry_l,
    output logic        res_wrap,
    output logic        oam_bug
);

    idu_state_t  state;
    logic [1:0]  op_q;
    logic [15:0] addr_q;
    logic [2:0]  tag_q;

    logic [15:0] sum;
    logic        carry_l;
    logic        wrap;
    logic        req_fire;

    // DONE can take a new request in the same cycle its result is consumed.
    assign req_ready = (state == IDLE) || ((state == DONE) && res_ready);
    assign res_valid = (state == DONE);
    assign req_fire  = req_valid && req_ready;

    sm83_idu_adder u_adder (
        .addr    (addr_q),
        .op      (op_q),
        .sum     (sum),
        .carry_l (carry_l),
        .wrap    (wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= 2'd0;
            addr_q      <= 16'd0;
            tag_q       <= 3'd0;
            res_addr    <= 16'd0;
            res_tag     <= 3'd0;
            res_carry_l <= 1'b0;
            res_wrap    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        op_q   <= req_op;
                        addr_q <= req_addr;
                        tag_q  <= req_tag;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    res_addr    <= sum;
                    res_tag     <= tag_q;
                    res_carry_l <= carry_l;
                    res_wrap    <= wrap;
                    state       <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        if (req_valid) begin
                            op_q   <= req_op;
                            addr_q <= req_addr;
                            tag_q  <= req_tag;
                            state  <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SM83_IDU_OAM_BUG_EN
    logic oam_bug_q;

    // Judged on the pre-operation pointer, registered alongside the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            oam_bug_q <= 1'b0;
        end else if (state == CALC) begin
            oam_bug_q <= ((op_q == INC) || (op_q == DEC)) &&
                         (addr_q >= OAM_LO) && (addr_q <= OAM_HI);
        end
    end

    assign oam_bug = oam_bug_q;
`else
    assign oam_bug = 1'b0;
`endif

endmodule

// File: tb/tb_sm83_idu_stage.sv
// tb/tb_sm83_idu_stage.sv - self-checking bench for sm83_idu_stage
module tb_sm83_idu_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_addr;
    logic [2:0]  req_tag;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_addr;
    logic [2:0]  res_tag;
    logic        res_carry_l;
    logic        res_wrap;
    logic        oam_bug;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [2:0]  t;
        logic        c;
        logic        w;
        logic        o;
    } exp_t;

    sm83_idu_stage dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_tag     (req_tag),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_addr    (res_addr),
        .res_tag     (res_tag),
        .res_carry_l (res_carry_l),
        .res_wrap    (res_wrap),
        .oam_bug     (oam_bug)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: integer arithmetic on the whole 16-bit value.
    function automatic exp_t model(input int op, input int addr, input int tag);
        exp_t e;
        e.a = addr[15:0];
        e.t = tag[2:0];
        e.c = 1'b0;
        e.w = 1'b0;
        if (op == 1) begin
            e.a = 16'((addr + 1) % 65536);
            e.c = ((addr % 256) == 255);
            e.w = (addr == 65535);
        end else if (op == 2) begin
            e.a = 16'((addr + 65535) % 65536);
            e.c = ((addr % 256) == 0);
            e.w = (addr == 0);
        end
`ifdef SM83_IDU_OAM_BUG_EN
        e.o = (op == 1 || op == 2) && addr >= 32'hFE00 && addr <= 32'hFEFF;
`else
        e.o = 1'b0;
`endif
        return e;
    endfunction

    task automatic check_res(input string tag, input exp_t e);
        check({tag, ".valid"}, res_valid, 1);
        check({tag, ".addr"}, res_addr, e.a);
        check({tag, ".tag"}, res_tag, e.t);
        check({tag, ".carry"}, res_carry_l, e.c);
        check({tag, ".wrap"}, res_wrap, e.w);
        check({tag, ".oam"}, oam_bug, e.o);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, res_valid, 0);
        check({tag, ".ready"}, req_ready, 1);
        check({tag, ".addr"}, res_addr, 0);
        check({tag, ".tag"}, res_tag, 0);
        check({tag, ".carry"}, res_carry_l, 0);
        check({tag, ".wrap"}, res_wrap, 0);
        check({tag, ".oam"}, oam_bug, 0);
    endtask

    // One transaction from IDLE: handshake, CALC, DONE held for `stall` cycles, consume.
    task automatic xact(input string tag, input int op, input int addr, input int tg, input int stall);
        exp_t e;
        e = model(op, addr, tg);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op[1:0];
        req_addr  = addr[15:0];
        req_tag   = tg[2:0];
        res_ready = 1'b0;
        check({tag, ".acc"}, req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        // Garbage on the request bus while no handshake is possible must be ignored.
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = 16'($urandom);
        req_tag   = 3'($urandom);
        check({tag, ".calc_valid"}, res_valid, 0);
        check({tag, ".calc_ready"}, req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check_res(tag, e);
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_res({tag, ".hold"}, e);
            check({tag, ".hold_ready"}, req_ready, 0);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, ".idle_valid"}, res_valid, 0);
        check({tag, ".idle_ready"}, req_ready, 1);
    endtask

    initial begin
        exp_t e1;
        exp_t e2;
        int   op;
        int   addr;
        int   edges[8];

        edges[0] = 0;      edges[1] = 16'hFFFF; edges[2] = 16'h00FF; edges[3] = 16'h0100;
        edges[4] = 16'hFE00; edges[5] = 16'hFEFF; edges[6] = 16'hFDFF; edges[7] = 16'hFF00;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_addr  = 16'd0;
        req_tag   = 3'd0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_zero("reset");

        xact("inc12ff", 1, 16'h12FF, 5, 0);
        xact("dec0000", 2, 16'h0000, 1, 0);
        xact("incffff", 1, 16'hFFFF, 2, 0);
        xact("incfe40", 1, 16'hFE40, 3, 0);
        xact("passfe40", 0, 16'hFE40, 4, 0);
        xact("op3", 3, 16'hFFFF, 6, 0);

        // Stall in DONE for 5 cycles, then consume while a new request is waiting.
        e1 = model(2, 16'h3400, 7);
        e2 = model(1, 16'h00FF, 2);
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd2; req_addr = 16'h3400; req_tag = 3'd7;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_res("stall0", e1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_res("stall", e1);
            check("stall.ready", req_ready, 0);
        end
        req_valid = 1'b1; req_op = 2'd1; req_addr = 16'h00FF; req_tag = 3'd2;
        res_ready = 1'b1;
        #1;
        check("b2b.ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        res_ready = 1'b0;
        check("b2b.calc_valid", res_valid, 0);
        check("b2b.calc_ready", req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check_res("b2b", e2);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;

        // Reset while the request sits in CALC.
        req_valid = 1'b1; req_op = 2'd1; req_addr = 16'hFE10; req_tag = 3'd5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_zero("rst_calc");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_calc.novalid", res_valid, 0);
        end

        for (int n = 0; n < 150; n++) begin
            op   = int'($urandom_range(0, 3));
            addr = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 7)] : int'($urandom_range(0, 65535));
            xact("rand", op, addr, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
